// File: rtl/multicycle_adder_nbit.sv
// ---------------------------------------------------------------------------
// multicycle_adder_nbit
//
// Iterative N-bit adder/subtractor. The carry chain is resolved K bits per
// clock, LSB chunk first, so a wide add closes timing at a higher clock
// rate than a full-width single-cycle chain. It computes A+B+Cin, or A-B
// when sub=1, under a start/busy/done handshake.
//
// Handshake: start is sampled only while idle (busy=0). The accepting edge
// latches A, B (inverted for sub), Cin (forced to 1 for sub). busy is then
// high for exactly M=N/K cycles. done pulses for one cycle after the last
// chunk, with busy already low. A start in the done cycle is accepted.
// start while busy is ignored and does not touch the latched operands.
//
// Optional feature macro: MCADD_FLAGS_EN
//   defined   : V (signed overflow) and Z (S==0) are computed and registered.
//   undefined : V and Z are tied to 0 and no flag logic is built.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request, sampled only when idle
//   sub        in   0: A+B+Cin, 1: A-B (Cin ignored)
//   A, B       in   N-bit operands, sampled with start
//   Cin        in   carry in, sampled with start
//   busy       out  operation in progress
//   done       out  one-cycle pulse, result valid
//   S          out  registered N-bit sum/difference
//   Cout       out  carry out of bit N-1 (sub: 1 = no borrow)
//   V          out  signed overflow
//   Z          out  S == 0
//   dbg_state  out  FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module multicycle_adder_nbit #(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic         V,
   output logic         Z,
   output logic         dbg_state
);

   localparam int M  = N / K;
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  s_q, s_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [K-1:0]  a_chunk;
   logic [K-1:0]  b_chunk;
   logic [K:0]    chunk_sum;
   logic [N-1:0]  result;
   logic          last_chunk;
   logic          msb_carry_in;

   // Current chunk slice and its K-bit add with the running carry.
   always_comb begin
      a_chunk   = a_q[cnt_q*K +: K];
      b_chunk   = b_q[cnt_q*K +: K];
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
      // Partial result with the current chunk merged in; on the last chunk
      // this is the complete result.
      result                = acc_q;
      result[cnt_q*K +: K]  = chunk_sum[K-1:0];
   end

   assign last_chunk   = (cnt_q == LAST);
   // Carry into the top bit of the chunk, recovered from the sum bit:
   // s = a ^ b ^ cin  =>  cin = a ^ b ^ s. Only meaningful on the last chunk.
   assign msb_carry_in = a_chunk[K-1] ^ b_chunk[K-1] ^ chunk_sum[K-1];

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               // Subtraction as A + ~B + 1.
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : Cin;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = result;
            carry_d = chunk_sum[K];
            if (last_chunk) begin
               s_d     = result;
               cout_d  = chunk_sum[K];
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

`ifdef MCADD_FLAGS_EN
   logic v_q;
   logic z_q;

   // Flags are captured together with S on the last chunk and held after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= 1'b0;
         z_q <= 1'b0;
      end else if (state_q == RUN && last_chunk) begin
         v_q <= msb_carry_in ^ chunk_sum[K];
         z_q <= (result == '0);
      end
   end

   assign V = v_q;
   assign Z = z_q;
`else
   assign V = 1'b0;
   assign Z = 1'b0;
`endif

   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_adder_nbit.sv
module tb_multicycle_adder_nbit;

  `ifdef MCADD_FLAGS_EN
  localparam logic FLAGS = 1'b1;
  `else
  localparam logic FLAGS = 1'b0;
  `endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 0: N=32, K=8
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, v, z, dbg;
  logic [31:0] s;

  // DUT 1: N=16, K=16
  logic        start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        busy2, done2, cout2, v2, z2, dbg2;
  logic [15:0] s2;

  multicycle_adder_nbit #(.N(32), .K(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .S(s), .Cout(cout), .V(v), .Z(z), .dbg_state(dbg)
  );

  multicycle_adder_nbit #(.N(16), .K(16)) dut_wide (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .A(a2), .B(b2), .Cin(cin2),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2), .V(v2), .Z(z2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver ----------------
  // Issues one request; returns edges from accept to done and busy violations.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic ts, output int lat, output int busy_bad);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_bad = 0;
    if (busy !== 1'b1 || dbg !== 1'b1) busy_bad++;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bb, gap, cnt;
    logic [31:0] exp_s;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000010, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_v", v, 0);
    check("rst_z", z, 0);
    check("rst_dbg", dbg, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_s", s, 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(vecs[i].s);
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bb);
      exp_s = exp_q.pop_front();
      check($sformatf("v%0d_latency", i), lat, 4);
      check($sformatf("v%0d_busy_window", i), bb, 0);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
      check($sformatf("v%0d_s", i), s, exp_s);
      check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("v%0d_v", i), v, vecs[i].v & FLAGS);
      check($sformatf("v%0d_z", i), z, vecs[i].z & FLAGS);
    end

    // ---- start while busy ignored, then start in the done cycle ----
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h0; b = 32'h0; start = 1'b1;
    check("hold_s_while_busy", s, 32'h01000000);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_latency", lat, 4);
    check("b2b_first_s", s, 32'h23456789);
    a = 32'h00000001; b = 32'h00000002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single_pulse", done, 0);
    check("b2b_accepted_busy", busy, 1);
    gap = 1;
    while (gap < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      gap++;
    end
    check("b2b_done_gap", gap, 5);
    check("b2b_second_s", s, 32'h00000003);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("no_queued_done", cnt, 0);

    // ---- reset mid-operation ----
    @(negedge clk);
    a = 32'h0F0F0F0F; b = 32'h00000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_s", s, 0);
    check("abort_cout", cout, 0);
    check("abort_v", v, 0);
    check("abort_z", z, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_s_held", s, 0);
    run_op(32'h3, 32'h4, 1'b0, 1'b0, lat, bb);
    check("after_abort_latency", lat, 4);
    check("after_abort_s", s, 32'h7);

    // ---- K = N: single-cycle operation ----
    @(negedge clk);
    a2 = 16'h8000; b2 = 16'h8000; cin2 = 1'b0; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("wide_busy", busy2, 1);
    check("wide_done_early", done2, 0);
    @(posedge clk); #1;
    check("wide_done", done2, 1);
    check("wide_busy_at_done", busy2, 0);
    check("wide_s", s2, 16'h0000);
    check("wide_cout", cout2, 1);
    check("wide_v", v2, FLAGS);
    check("wide_z", z2, FLAGS);
    @(posedge clk); #1;
    check("wide_done_pulse", done2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
